jtag_scan_master: RTL and testbench

// Clocked JTAG master that sequences the TAP from a command interface, replacing

---
 rtl/jtag_scan_master.sv | 199 +++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: command-driven JTAG master.
// Takes TLR-reset, IR-scan and DR-scan commands and walks the TAP through them.
// TCK is derived from clk. TMS and TDI are driven once per TCK step. TDO bits
// captured in Shift-xR are returned on the response interface.
//
// Ports
//   clk, reset       system clock; asynchronous active-high reset
//   cmd_valid/ready  command handshake; ready only while idle in Run-Test-Idle
//   cmd_op           0 TLR reset, 1 IR scan, 2 DR scan, 3 reserved (rejected)
//   cmd_len          DR scan length 1..MAX_BITS (IR scans use IR_LENGTH)
//   cmd_data         TDI bits, LSB shifted first
//   cmd_pause        route Exit1 -> Pause -> Exit2 -> Update instead of Exit1 -> Update
//   rsp_valid/err    one-clk completion pulse; err marks a rejected command
//   rsp_data         captured TDO, bit i from shift step i, upper bits zero
//   busy             inverse of cmd_ready
//   tck, tms, tdi    JTAG outputs; tdo JTAG input
module jtag_scan_master #(
    parameter int unsigned IR_LENGTH = 4,
    parameter int unsigned MAX_BITS  = 64,
    parameter int unsigned TCK_DIV   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [6:0]          cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    input  logic                cmd_pause,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int unsigned     DivW    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int unsigned     IdxW    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TCK_DIV - 1);
    localparam logic [6:0]      IrLen   = 7'(IR_LENGTH);
    localparam logic [6:0]      MaxLen  = 7'(MAX_BITS);

    // Step states are named after the TAP state the TAP occupies during the step.
    typedef enum logic [3:0] {
        StIdle, StTlr, StRti, StSelDr, StSelIr, StCapture, StShift,
        StExit1, StPause, StExit2, StUpdate, StDone
    } state_e;

    state_e                state_q;
    logic [DivW-1:0]       div_q;
    logic [6:0]            bit_q;
    logic [6:0]            len_q;
    logic                  is_ir_q;
    logic                  pause_q;
    logic                  auto_q;   // TLR issued by reset: completes without a response
    logic                  err_q;
    logic [MAX_BITS-1:0]   data_q;
    logic [MAX_BITS-1:0]   cap_q;
    logic [6:0]            bit_inc;

    assign bit_inc = bit_q + 7'd1;
    assign busy    = ~cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StTlr;
            div_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            is_ir_q   <= 1'b0;
            pause_q   <= 1'b0;
            auto_q    <= 1'b1;
            err_q     <= 1'b0;
            data_q    <= '0;
            cap_q     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        data_q    <= cmd_data;
                        pause_q   <= cmd_pause;
                        cap_q     <= '0;
                        div_q     <= '0;
                        bit_q     <= '0;
                        is_ir_q   <= (cmd_op == 2'd1);
                        len_q     <= (cmd_op == 2'd1) ? IrLen : cmd_len;
                        if (cmd_op == 2'd3 ||
                            (cmd_op == 2'd2 && (cmd_len == 7'd0 || cmd_len > MaxLen))) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            tms     <= 1'b1;
                            state_q <= (cmd_op == 2'd0) ? StTlr : StRti;
                        end
                    end
                end
                StDone: begin
                    rsp_valid <= ~auto_q;
                    rsp_err   <= err_q;
                    if (!auto_q) begin
                        rsp_data <= err_q ? '0 : cap_q;
                    end
                    auto_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    // Stepping: low half then high half, each TCK_DIV clks long.
                    if (div_q != DivLast) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                            if (state_q == StShift) begin
                                cap_q[bit_q[IdxW-1:0]] <= tdo;
                            end
                        end else begin
                            // Falling edge ends the step; set up TMS/TDI for the next one.
                            tck <= 1'b0;
                            unique case (state_q)
                                StTlr: begin
                                    if (bit_q == 7'd5) begin
                                        tms     <= 1'b0;
                                        state_q <= StDone;
                                    end else begin
                                        bit_q <= bit_inc;
                                        tms   <= (bit_q != 7'd4);
                                    end
                                end
                                StRti: begin
                                    tms     <= is_ir_q;
                                    state_q <= StSelDr;
                                end
                                StSelDr: begin
                                    tms     <= 1'b0;
                                    state_q <= is_ir_q ? StSelIr : StCapture;
                                end
                                StSelIr: begin
                                    tms     <= 1'b0;
                                    state_q <= StCapture;
                                end
                                StCapture: begin
                                    bit_q   <= '0;
                                    tms     <= (len_q == 7'd1);
                                    tdi     <= data_q[0];
                                    state_q <= StShift;
                                end
                                StShift: begin
                                    if (bit_inc == len_q) begin
                                        tms     <= ~pause_q;
                                        tdi     <= 1'b0;
                                        state_q <= StExit1;
                                    end else begin
                                        bit_q <= bit_inc;
                                        tms   <= ((bit_inc + 7'd1) == len_q);
                                        tdi   <= data_q[bit_inc[IdxW-1:0]];
                                    end
                                end
                                StExit1: begin
                                    tms     <= pause_q;
                                    state_q <= pause_q ? StPause : StUpdate;
                                end
                                StPause: begin
                                    tms     <= 1'b1;
                                    state_q <= StExit2;
                                end
                                StExit2: begin
                                    tms     <= 1'b0;
                                    state_q <= StUpdate;
                                end
                                StUpdate: begin
                                    tms     <= 1'b0;
                                    state_q <= StDone;
                                end
                                default: state_q <= StIdle;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
module tb_jtag_scan_master;

    localparam logic [31:0] IdcodeVal = 32'h149511C3;
    localparam logic [3:0]  IrIdcode  = 4'hE;
    localparam logic [3:0]  IrUser    = 4'h5;
    localparam logic [63:0] UserCap   = 64'hA5C3_0F1E_9B7D_2468;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [6:0]  cmd_len = '0;
    logic [63:0] cmd_data = '0;
    logic        cmd_pause = 1'b0;
    logic        rsp_valid, rsp_err, busy, tck, tms, tdi;
    logic [63:0] rsp_data;
    logic        tdo = 1'b0;

    jtag_scan_master #(.IR_LENGTH(4), .MAX_BITS(64), .TCK_DIV(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_pause(cmd_pause),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural TAP controller with IR, IDCODE and a 64-bit user register.
    typedef enum int {
        TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPaDr, TapEx2Dr, TapUpDr,
        TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPaIr, TapEx2Ir, TapUpIr
    } tap_e;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TapTlr:   return m ? TapTlr   : TapRti;
            TapRti:   return m ? TapSelDr : TapRti;
            TapSelDr: return m ? TapSelIr : TapCapDr;
            TapCapDr: return m ? TapEx1Dr : TapShDr;
            TapShDr:  return m ? TapEx1Dr : TapShDr;
            TapEx1Dr: return m ? TapUpDr  : TapPaDr;
            TapPaDr:  return m ? TapEx2Dr : TapPaDr;
            TapEx2Dr: return m ? TapUpDr  : TapShDr;
            TapUpDr:  return m ? TapSelDr : TapRti;
            TapSelIr: return m ? TapTlr   : TapCapIr;
            TapCapIr: return m ? TapEx1Ir : TapShIr;
            TapShIr:  return m ? TapEx1Ir : TapShIr;
            TapEx1Ir: return m ? TapUpIr  : TapPaIr;
            TapPaIr:  return m ? TapEx2Ir : TapPaIr;
            TapEx2Ir: return m ? TapUpIr  : TapShIr;
            default:  return m ? TapSelDr : TapRti;
        endcase
    endfunction

    tap_e        tap_st = TapTlr;
    logic [3:0]  ir = IrIdcode;
    logic [3:0]  ir_sr = '0;
    logic [63:0] dr_sr = '0;
    logic [63:0] shin = '0;
    int          sh_n = 0;
    logic [63:0] upd_dr = '0;
    int          upd_len = 0;
    bit          tms_log[$];
    int          rise_cyc[$];
    int          n_rise = 0;
    int          n_fall = 0;

    always @(posedge tck) begin
        tms_log.push_back(tms);
        rise_cyc.push_back(cyc);
        n_rise++;
        case (tap_st)
            TapTlr:   ir = IrIdcode;
            TapCapIr: begin ir_sr = 4'b0001; sh_n = 0; shin = '0; end
            TapShIr:  begin shin[sh_n] = tdi; sh_n++; ir_sr = {tdi, ir_sr[3:1]}; end
            TapUpIr:  ir = ir_sr;
            TapCapDr: begin
                dr_sr = (ir == IrIdcode) ? {32'h0, IdcodeVal} : UserCap;
                sh_n = 0;
                shin = '0;
            end
            TapShDr:  begin shin[sh_n] = tdi; sh_n++; dr_sr = {tdi, dr_sr[63:1]}; end
            TapUpDr:  begin upd_dr = shin; upd_len = sh_n; end
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        n_fall++;
        tdo = (tap_st == TapShIr) ? ir_sr[0] : (tap_st == TapShDr) ? dr_sr[0] : 1'b0;
    end

    int          n_rsp = 0;
    int          rsp_cyc = 0;
    logic [63:0] got_data = '0;
    logic        got_err = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid) begin
            n_rsp++;
            got_data = rsp_data;
            got_err  = rsp_err;
            rsp_cyc  = cyc;
        end
    end

    bit exp_tms[$];

    // Expected TMS per step, built from the TAP walk for each command kind.
    task automatic build_exp(input int op, input int n, input bit pause);
        exp_tms.delete();
        if (op == 0) begin
            repeat (5) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end else begin
            exp_tms.push_back(1'b1);
            if (op == 1) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
            if (pause) begin
                exp_tms.push_back(1'b0);
                exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b1);
            end else begin
                exp_tms.push_back(1'b1);
            end
            exp_tms.push_back(1'b0);
        end
    endtask

    task automatic check_tms(input string tag);
        int bad = 0;
        check({tag, "_steps"}, 64'(tms_log.size()), 64'(exp_tms.size()));
        for (int i = 0; i < tms_log.size() && i < exp_tms.size(); i++)
            if (tms_log[i] != exp_tms[i]) bad++;
        check({tag, "_tms"}, 64'(bad), 64'h0);
    endtask

    task automatic clear_logs();
        tms_log.delete();
        rise_cyc.delete();
        n_rise = 0;
        n_fall = 0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 64'(cmd_ready), 64'h1);
    endtask

    int c0 = 0;

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [6:0] len,
                           input logic [63:0] data, input logic pause);
        int rsp0;
        int k = 0;
        wait_ready({tag, "_pre"});
        clear_logs();
        rsp0 = n_rsp;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_pause = pause;
        cmd_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = {$urandom, $urandom};
        while (n_rsp == rsp0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_nrsp"}, 64'(n_rsp - rsp0), 64'h1);
        wait_ready(tag);
        check({tag, "_rti"}, 64'(tap_st == TapRti), 64'h1);
    endtask

    function automatic logic [63:0] mask(input int n);
        return (n >= 64) ? '1 : ((64'h1 << n) - 64'h1);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit pz;
        logic [63:0] d;
        logic [3:0] v;
        int rsp0;
        int k;

        // Reset values and auto TLR
        repeat (3) @(negedge clk);
        check("reset_pins", 64'({tck, tms, tdi, cmd_ready, busy, rsp_valid, rsp_err}),
              64'(7'b0100100));
        check("reset_data", rsp_data, 64'h0);
        clear_logs();
        reset = 1'b0;
        k = 0;
        while (!cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tlr_ready", 64'(cmd_ready), 64'h1);
        check("tlr_rise", 64'(n_rise), 64'd6);
        check("tlr_fall", 64'(n_fall), 64'd6);
        check("tlr_tck_low", 64'(tck), 64'h0);
        check("tlr_period", 64'((rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : 0), 64'd8);
        build_exp(0, 0, 1'b0);
        check_tms("tlr");
        check("tlr_norsp", 64'(n_rsp), 64'h0);
        check("tlr_rti", 64'(tap_st == TapRti), 64'h1);

        // IR scan 4'hA
        run_cmd("ir_a", 2'd1, 7'd0, 64'hA, 1'b0);
        build_exp(1, 4, 1'b0);
        check_tms("ir_a");
        check("ir_a_err", 64'(got_err), 64'h0);
        check("ir_a_data", got_data, 64'h1);
        check("ir_a_ir", 64'(ir), 64'hA);

        // IDCODE read
        run_cmd("ir_id", 2'd1, 7'd0, 64'(IrIdcode), 1'b0);
        run_cmd("dr_id", 2'd2, 7'd32, 64'h0, 1'b0);
        check("dr_id_data", got_data, 64'(IdcodeVal));
        build_exp(2, 32, 1'b0);
        check_tms("dr_id");

        // DR with pause
        run_cmd("ir_user", 2'd1, 7'd0, 64'(IrUser), 1'b0);
        run_cmd("dr_p", 2'd2, 7'd4, 64'h9, 1'b1);
        build_exp(2, 4, 1'b1);
        check_tms("dr_p");
        check("dr_p_upd", upd_dr, 64'h9);
        check("dr_p_updlen", 64'(upd_len), 64'd4);
        check("dr_p_data", got_data, UserCap & mask(4));

        // Rejected commands
        for (int e = 0; e < 3; e++) begin
            string t;
            t = (e == 0) ? "err_len0" : (e == 1) ? "err_len65" : "err_op3";
            run_cmd(t, (e == 2) ? 2'd3 : 2'd2, (e == 0) ? 7'd0 : (e == 1) ? 7'd65 : 7'd8,
                    64'hFFFF, 1'b0);
            check({t, "_err"}, 64'(got_err), 64'h1);
            check({t, "_data"}, got_data, 64'h0);
            check({t, "_tck"}, 64'(n_rise + n_fall), 64'h0);
            check({t, "_lat"}, 64'((rsp_cyc - c0) >= 1 && (rsp_cyc - c0) <= 2), 64'h1);
        end

        // Randomised DR scans against the user register
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(64, 1);
            pz  = 1'($urandom_range(1, 0));
            d   = {$urandom, $urandom};
            run_cmd("rnd", 2'd2, 7'(len), d, pz);
            build_exp(2, len, pz);
            check_tms("rnd");
            check("rnd_err", 64'(got_err), 64'h0);
            check("rnd_data", got_data, UserCap & mask(len));
            check("rnd_upd", upd_dr, d & mask(len));
            check("rnd_updlen", 64'(upd_len), 64'(len));
        end

        // Random IR value, then an explicit TLR command
        v = 4'($urandom_range(15, 0));
        run_cmd("ir_rnd", 2'd1, 7'd0, 64'(v), 1'b1);
        build_exp(1, 4, 1'b1);
        check_tms("ir_rnd");
        check("ir_rnd_ir", 64'(ir), 64'(v));
        run_cmd("tlr_cmd", 2'd0, 7'd0, 64'h0, 1'b0);
        build_exp(0, 0, 1'b0);
        check_tms("tlr_cmd");
        check("tlr_cmd_err", 64'(got_err), 64'h0);
        check("tlr_cmd_ir", 64'(ir), 64'(IrIdcode));

        // Reset during a DR shift
        run_cmd("ir_user2", 2'd1, 7'd0, 64'(IrUser), 1'b0);
        wait_ready("abort_pre");
        rsp0 = n_rsp;
        cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = 64'hDEAD_BEEF; cmd_pause = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(tap_st == TapShDr && sh_n >= 10) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached", 64'(sh_n), 64'd10);
        reset = 1'b1;
        #1;
        check("abort_tck", 64'(tck), 64'h0);
        check("abort_tms", 64'(tms), 64'h1);
        repeat (3) @(negedge clk);
        clear_logs();
        reset = 1'b0;
        wait_ready("abort_tlr");
        build_exp(0, 0, 1'b0);
        check_tms("abort_tlr");
        check("abort_norsp", 64'(n_rsp - rsp0), 64'h0);
        run_cmd("ir_id2", 2'd1, 7'd0, 64'(IrIdcode), 1'b0);
        run_cmd("dr_id2", 2'd2, 7'd32, 64'h0, 1'b0);
        check("dr_id2_data", got_data, 64'(IdcodeVal));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
